// File: rtl/iir_result_capture.sv
// Capture buffer for the filtered output stream. Stores up to 2**ADDR_W samples,
// tracks stream-integrity flags and replays the block over a valid/ready port.
module iir_result_capture #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_out_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stable_out,
    input  logic              filter_done,
    input  logic              rd_start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [ADDR_W:0]   cap_count,
    output logic              cap_done,
    output logic              busy,
    output logic              overflow,
    output logic              addr_err,
    output logic              unstable_seen,
    output logic [1:0]        state_dbg
);

    // Readback handshake: a beat transfers on a rising edge where rd_valid && rd_ready.
    // While rd_valid is high and rd_ready low, rd_data/rd_last hold their values.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ram_q;
    logic              ram_vld;
    logic              ram_last;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              skid_last;
    logic [ADDR_W:0]   rd_ptr;

    logic              cap_we;
    logic              cap_full;
    logic              start_fire;
    logic              pop;
    logic              issue_rd;
    logic [1:0]        occ;
    logic [ADDR_W:0]   rd_addr_ext;

    assign cap_we      = data_out_valid && (state == S_CAPTURE) && !arm && !rst;
    assign cap_full    = (cap_count == FULL);
    assign start_fire  = (state == S_DONE) && rd_start && !arm && (cap_count != '0);
    assign pop         = rd_valid && rd_ready;
    assign occ         = {1'b0, rd_valid} + {1'b0, skid_valid} + {1'b0, ram_vld};
    assign rd_addr_ext = start_fire ? '0 : rd_ptr;

    // A read is issued only if its data is guaranteed a slot (output reg or skid)
    // when it returns one cycle later, even if nothing drains meanwhile.
    assign issue_rd = !rst && !arm &&
                      (start_fire ||
                       ((state == S_READOUT) && (rd_ptr < cap_count) &&
                        (occ <= (pop ? 2'd2 : 2'd1))));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (arm) begin
            state_nx = S_CAPTURE;
        end else begin
            case (state)
                S_IDLE:    state_nx = S_IDLE;
                S_CAPTURE: begin
                    if (filter_done || (cap_we && (cap_count == FULL - CNT_ONE))) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    if (start_fire) begin
                        state_nx = S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (pop && rd_last) begin
                        state_nx = S_DONE;
                    end
                end
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        cap_done  = (state == S_DONE);
        busy      = (state == S_CAPTURE) || (state == S_READOUT);
        state_dbg = state;
    end

    // Sample buffer: never reset, write pointer is the capture count.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            mem[cap_count[ADDR_W-1:0]] <= data_out;
        end
        if (issue_rd) begin
            ram_q <= mem[rd_addr_ext[ADDR_W-1:0]];
        end
    end

    // Capture status and flags
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            cap_count     <= '0;
            overflow      <= 1'b0;
            addr_err      <= 1'b0;
            unstable_seen <= 1'b0;
        end else begin
            if (cap_we) begin
                cap_count <= cap_count + CNT_ONE;
                if (addr != cap_count[ADDR_W-1:0]) begin
                    addr_err <= 1'b1;
                end
                if (!stable_out) begin
                    unstable_seen <= 1'b1;
                end
            end
            if ((state == S_DONE) && data_out_valid && cap_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Readback pipeline: RAM output stage feeding output register plus skid entry.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            rd_ptr     <= '0;
            ram_vld    <= 1'b0;
            ram_last   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else begin
            ram_vld  <= issue_rd;
            ram_last <= issue_rd && (rd_addr_ext == cap_count - CNT_ONE);
            if (issue_rd) begin
                rd_ptr <= rd_addr_ext + CNT_ONE;
            end

            if (pop) begin
                if (skid_valid) begin
                    rd_valid   <= 1'b1;
                    rd_data    <= skid_data;
                    rd_last    <= skid_last;
                    skid_valid <= ram_vld;
                    skid_data  <= ram_q;
                    skid_last  <= ram_vld && ram_last;
                end else begin
                    rd_valid <= ram_vld;
                    rd_data  <= ram_q;
                    rd_last  <= ram_vld && ram_last;
                end
            end else if (!rd_valid) begin
                rd_valid <= ram_vld;
                rd_data  <= ram_q;
                rd_last  <= ram_vld && ram_last;
            end else if (ram_vld) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= ram_last;
            end
        end
    end

endmodule

// File: tb/tb_iir_result_capture.sv
// Directed bench for iir_result_capture: capture, flags, stalled/unstalled
// readback, restart and reset behaviour.
module tb_iir_result_capture;

    logic        clk;
    logic        rst;
    logic        arm;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [10:0] addr;
    logic        stable_out;
    logic        filter_done;
    logic        rd_start;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic [11:0] cap_count;
    logic        cap_done;
    logic        busy;
    logic        overflow;
    logic        addr_err;
    logic        unstable_seen;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] exp_q[$];

    iir_result_capture #(.DATA_W(16), .ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .data_out(data_out), .data_out_valid(data_out_valid), .addr(addr),
        .stable_out(stable_out), .filter_done(filter_done), .rd_start(rd_start),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .cap_count(cap_count), .cap_done(cap_done), .busy(busy),
        .overflow(overflow), .addr_err(addr_err), .unstable_seen(unstable_seen),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample and drive point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_filter_done();
        filter_done = 1'b1;
        tick();
        filter_done = 1'b0;
    endtask

    // Starts a readback and drains it, checking order, rd_last and hold-while-stalled.
    task automatic readback(input int n, input bit stall);
        int          got;
        int          cyc;
        bit          done;
        bit          prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        logic [15:0] exp_v;
        got = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("rd_lat_e0_valid", 32'(rd_valid), 0);
        chk("rd_state_readout", 32'(state_dbg), 3);
        chk("rd_busy", 32'(busy), 1);
        tick();
        chk("rd_lat_e1_valid", 32'(rd_valid), 1);
        while (!done && cyc < 8000) begin
            if (prev_stall) begin
                chk("rd_hold_valid", 32'(rd_valid), 1);
                chk("rd_hold_data", 32'(rd_data), 32'(prev_data));
                chk("rd_hold_last", 32'(rd_last), 32'(prev_last));
            end
            if (!stall) begin
                chk("rd_stream_valid", 32'(rd_valid), 1);
            end
            if (stall) begin
                rd_ready = (cyc < 64) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            end else begin
                rd_ready = 1'b1;
            end
            if (rd_valid && rd_ready) begin
                exp_v = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(exp_v));
                chk("rd_last", 32'(rd_last), 32'(exp_q.size() == 0));
                got++;
                done = (exp_q.size() == 0);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_beat_count", 32'(got), 32'(n));
        chk("rd_end_cap_done", 32'(cap_done), 1);
        chk("rd_end_valid", 32'(rd_valid), 0);
        exp_q.delete();
    endtask

    initial begin
        int acc;
        int cyc;
        rst = 1'b1; arm = 1'b0; data_out = '0; data_out_valid = 1'b0; addr = '0;
        stable_out = 1'b1; filter_done = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_last", 32'(rd_last), 0);
        chk("rst_cap_count", 32'(cap_count), 0);
        chk("rst_cap_done", 32'(cap_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({overflow, addr_err, unstable_seen}), 0);

        // Full 2048-sample capture, data = addr = index
        pulse_arm();
        chk("arm_state", 32'(state_dbg), 1);
        chk("arm_busy", 32'(busy), 1);
        for (int i = 0; i < 2048; i++) begin
            data_out = 16'(i); addr = 11'(i); data_out_valid = 1'b1;
            tick();
            if (i == 0) chk("cnt_after_first", 32'(cap_count), 1);
            if (i == 2046) chk("still_capture", 32'(state_dbg), 1);
        end
        data_out_valid = 1'b0;
        chk("full_cap_done", 32'(cap_done), 1);
        chk("full_busy", 32'(busy), 0);
        chk("full_count", 32'(cap_count), 2048);
        chk("full_addr_err", 32'(addr_err), 0);
        chk("full_overflow", 32'(overflow), 0);
        chk("full_unstable", 32'(unstable_seen), 0);

        // One beat with the buffer full, then a late filter_done
        data_out = 16'hDEAD; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(cap_count), 2048);
        pulse_filter_done();
        chk("late_fd_state", 32'(state_dbg), 2);

        // Unstalled readback of the full buffer
        for (int i = 0; i < 2048; i++) exp_q.push_back(16'(i));
        readback(2048, 1'b0);

        // Stalled readback of the same data
        for (int i = 0; i < 2048; i++) exp_q.push_back(16'(i));
        readback(2048, 1'b1);
        chk("ovf_persist", 32'(overflow), 1);

        // Short block ending with filter_done on beat 100
        pulse_arm();
        chk("rearm_ovf_clr", 32'(overflow), 0);
        chk("rearm_count", 32'(cap_count), 0);
        chk("rearm_cap_done", 32'(cap_done), 0);
        for (int i = 0; i < 100; i++) begin
            data_out = 16'hA000 + 16'(i); addr = 11'(i); data_out_valid = 1'b1;
            filter_done = (i == 99);
            tick();
        end
        data_out_valid = 1'b0; filter_done = 1'b0;
        chk("blk100_count", 32'(cap_count), 100);
        chk("blk100_done", 32'(cap_done), 1);
        data_out = 16'hFFFF; data_out_valid = 1'b1;
        tick();
        data_out_valid = 1'b0;
        chk("blk100_extra_count", 32'(cap_count), 100);
        chk("blk100_extra_ovf", 32'(overflow), 0);
        for (int i = 0; i < 100; i++) exp_q.push_back(16'hA000 + 16'(i));
        readback(100, 1'b1);

        // Address skip 5->7 and stability loss on beat 9
        pulse_arm();
        for (int i = 0; i < 12; i++) begin
            data_out = 16'h5000 + 16'(i);
            addr = (i < 6) ? 11'(i) : 11'(i + 1);
            stable_out = (i != 9);
            data_out_valid = 1'b1;
            tick();
            if (i == 5) chk("skip_pre_addr_err", 32'(addr_err), 0);
            if (i == 6) chk("skip_addr_err", 32'(addr_err), 1);
            if (i == 8) chk("pre_unstable", 32'(unstable_seen), 0);
            if (i == 9) chk("unstable_set", 32'(unstable_seen), 1);
        end
        data_out_valid = 1'b0; stable_out = 1'b1;
        pulse_filter_done();
        chk("skip_count", 32'(cap_count), 12);
        for (int i = 0; i < 12; i++) exp_q.push_back(16'h5000 + 16'(i));
        readback(12, 1'b0);
        chk("flags_persist", 32'({addr_err, unstable_seen}), 3);
        pulse_arm();
        chk("arm_clr_addr_err", 32'(addr_err), 0);
        chk("arm_clr_unstable", 32'(unstable_seen), 0);

        // Reset in the middle of a readback
        for (int i = 0; i < 512; i++) begin
            data_out = 16'h3000 + 16'(i); addr = 11'(i); data_out_valid = 1'b1;
            tick();
        end
        data_out_valid = 1'b0;
        pulse_filter_done();
        chk("mid_count", 32'(cap_count), 512);
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        acc = 0; cyc = 0;
        while (acc < 300 && cyc < 1000) begin
            if (rd_valid) begin
                chk("mid_data", 32'(rd_data), 32'h3000 + acc);
                acc++;
            end
            tick();
            cyc++;
        end
        chk("mid_reached_300", 32'(acc), 300);
        chk("mid_beat300_data", 32'(rd_data), 32'h312C);
        chk("mid_beat300_valid", 32'(rd_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(state_dbg), 0);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_count", 32'(cap_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(rd_data), 0);

        // rd_start with nothing captured: no beats
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("idle_start_valid", 32'(rd_valid), 0);
            chk("idle_start_state", 32'(state_dbg), 0);
            tick();
        end
        pulse_arm();
        pulse_filter_done();
        chk("empty_done", 32'(cap_done), 1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("empty_start_valid", 32'(rd_valid), 0);
            chk("empty_start_state", 32'(state_dbg), 2);
            tick();
        end
        rd_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
